nbuf_stream_ctrl: RTL and testbench

// - Parametrised N-way buffer controller for the accelerator's activation/weight SRAM space; generalises the fixed 2-way ping-pong split to NUM_BUF ring buffers.
// - Producer side: external 32-bit write port streams words into the current fill buffer, and this block generates the byte addresses.
// - Consumer side: array control acquires one committed buffer at a time and releases it when done.
// - Tracks per-buffer state; never lets the producer overwrite a buffer that is not yet released.

---
 rtl/nbuf_stream_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_nbuf_stream_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nbuf_stream_ctrl.sv
// nbuf_stream_ctrl: N-way ring buffer controller for the accelerator SRAM.
// The producer streams 32-bit words into the current fill buffer, and this
// block generates the byte addresses. The consumer acquires one committed
// buffer at a time and releases it when it is done.
// Optional feature macro: NBUF_OCCUPANCY_EN adds the occ_o/peak_o occupancy outputs.
module nbuf_stream_ctrl #(
    parameter int NUM_BUF    = 2,
    parameter int BUF_SIZE   = 32768,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = $clog2(NUM_BUF * BUF_SIZE),
    parameter int CNT_W      = $clog2(BUF_SIZE / WORD_BYTES) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic              wr_last_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [ADDR_W-1:0] rd_base_o,
    output logic [CNT_W-1:0]  rd_len_o,
    input  logic              rd_done_i,
    output logic              ovf_o
`ifdef NBUF_OCCUPANCY_EN
    ,
    output logic [$clog2(NUM_BUF+1)-1:0] occ_o,
    output logic [$clog2(NUM_BUF+1)-1:0] peak_o
`endif
);

    localparam int WORDS   = BUF_SIZE / WORD_BYTES;
    localparam int PTR_W   = $clog2(NUM_BUF);
    localparam int OFF_W   = $clog2(BUF_SIZE);
    localparam int BYTE_SH = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } buf_state_e;

    buf_state_e        state_q [NUM_BUF];
    buf_state_e        state_d [NUM_BUF];
    logic [CNT_W-1:0]  len_q   [NUM_BUF];
    logic [CNT_W-1:0]  len_d   [NUM_BUF];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  held_ptr_q, held_ptr_d;
    logic              held_q, held_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic [CNT_W-1:0]  rd_len_q, rd_len_d;
    logic              ovf_q, ovf_d;

    logic              last_slot;
    logic              commit;
    logic              rd_hs;
    logic              rd_release;

    // Producer-side decode: readiness comes only from registered buffer state
    always_comb begin
        wr_ready_o = (state_q[wr_ptr_q] == ST_EMPTY) || (state_q[wr_ptr_q] == ST_FILLING);
        wr_en_o    = wr_valid_i & wr_ready_o;
        wr_addr_o  = (ADDR_W'(wr_ptr_q) << OFF_W) + (ADDR_W'(cnt_q) << BYTE_SH);
        last_slot  = (cnt_q == CNT_W'(WORDS - 1));
        commit     = wr_en_o & (wr_last_i | last_slot);
        rd_hs      = rd_valid_q & rd_ready_i;
        rd_release = held_q & rd_done_i;
    end

    // Next-state for buffer states, pointers and the consumer-facing registers
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        held_ptr_d = held_ptr_q;
        held_d     = held_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        rd_base_d  = rd_base_q;
        rd_len_d   = rd_len_q;

        if (wr_en_o) begin
            if (commit) begin
                state_d[wr_ptr_q] = ST_FULL;
                len_d[wr_ptr_q]   = cnt_q + 1'b1;
                wr_ptr_d          = wr_ptr_q + 1'b1;
                cnt_d             = '0;
                // A buffer filled to its final slot without wr_last_i overflowed
                if (!wr_last_i) begin
                    ovf_d = 1'b1;
                end
            end else begin
                state_d[wr_ptr_q] = ST_FILLING;
                cnt_d             = cnt_q + 1'b1;
            end
        end

        // The offered buffer is always FULL and the fill buffer never is,
        // so the handshake and the write never touch the same entry.
        if (rd_hs) begin
            state_d[rd_ptr_q] = ST_DRAINING;
            held_ptr_d        = rd_ptr_q;
            held_d            = 1'b1;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end

        if (rd_release) begin
            state_d[held_ptr_q] = ST_EMPTY;
            held_d              = 1'b0;
        end

        // Offer the buffer at rd_ptr once its FULL state has been registered;
        // base/len freeze while a buffer is held by the consumer.
        rd_valid_d = !held_d && !rd_hs && (state_q[rd_ptr_q] == ST_FULL);
        if (!held_d) begin
            rd_base_d = ADDR_W'(rd_ptr_q) << OFF_W;
            rd_len_d  = len_q[rd_ptr_q];
        end

        // Synchronous flush overrides every other event
        if (clear_i) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                state_d[i] = ST_EMPTY;
                len_d[i]   = '0;
            end
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            held_ptr_d = '0;
            held_d     = 1'b0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            rd_valid_d = 1'b0;
            rd_base_d  = '0;
            rd_len_d   = '0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                state_q[i] <= ST_EMPTY;
                len_q[i]   <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            held_ptr_q <= '0;
            held_q     <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_base_q  <= '0;
            rd_len_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_BUF; i++) begin
                state_q[i] <= state_d[i];
                len_q[i]   <= len_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            held_ptr_q <= held_ptr_d;
            held_q     <= held_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_base_q  <= rd_base_d;
            rd_len_q   <= rd_len_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_base_o  = rd_base_q;
    assign rd_len_o   = rd_len_q;
    assign ovf_o      = ovf_q;

`ifdef NBUF_OCCUPANCY_EN
    localparam int OCC_W = $clog2(NUM_BUF + 1);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] peak_q, peak_d;

    // Occupancy lags the registered buffer state by one cycle; peak tracks its maximum
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < NUM_BUF; i++) begin
            if ((state_q[i] == ST_FULL) || (state_q[i] == ST_DRAINING)) begin
                occ_d = occ_d + OCC_W'(1);
            end
        end
        peak_d = (occ_d > peak_q) ? occ_d : peak_q;
        if (clear_i) begin
            occ_d  = '0;
            peak_d = '0;
        end
    end

    // Occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q  <= '0;
            peak_q <= '0;
        end else begin
            occ_q  <= occ_d;
            peak_q <= peak_d;
        end
    end

    assign occ_o  = occ_q;
    assign peak_o = peak_q;
`endif

endmodule

// File: tb/tb_nbuf_stream_ctrl.sv
// Testbench for nbuf_stream_ctrl (NUM_BUF=2, BUF_SIZE=64 -> 16 words/buffer).
// A queue-based model of committed buffers predicts every output each cycle.
module tb_nbuf_stream_ctrl;

    localparam int NB     = 2;
    localparam int BS     = 64;
    localparam int WB     = 4;
    localparam int WORDS  = BS / WB;
    localparam int ADDR_W = $clog2(NB * BS);
    localparam int CNT_W  = $clog2(WORDS) + 1;
    localparam int OCC_W  = $clog2(NB + 1);

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              clear_i;
    logic              wr_valid_i;
    logic              wr_ready_o;
    logic              wr_last_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic              rd_valid_o;
    logic              rd_ready_i;
    logic [ADDR_W-1:0] rd_base_o;
    logic [CNT_W-1:0]  rd_len_o;
    logic              rd_done_i;
    logic              ovf_o;
`ifdef NBUF_OCCUPANCY_EN
    logic [OCC_W-1:0]  occ_o;
    logic [OCC_W-1:0]  peak_o;
`endif

    nbuf_stream_ctrl #(
        .NUM_BUF    (NB),
        .BUF_SIZE   (BS),
        .WORD_BYTES (WB)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_last_i  (wr_last_i),
        .wr_en_o    (wr_en_o),
        .wr_addr_o  (wr_addr_o),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_base_o  (rd_base_o),
        .rd_len_o   (rd_len_o),
        .rd_done_i  (rd_done_i),
        .ovf_o      (ovf_o)
`ifdef NBUF_OCCUPANCY_EN
        ,
        .occ_o      (occ_o),
        .peak_o     (peak_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: ring of buffers described by a FIFO of committed ones
    int cq[$];           // committed buffers in order, awaiting the consumer
    int mlen [NB];       // committed length per buffer
    int wbuf;            // current fill buffer
    int wcnt;            // words written into it so far
    bit m_held;          // consumer holds a buffer
    int hbuf;            // which one
    bit m_valid;         // expected rd_valid_o this cycle
    bit m_ovf;
    bit m_fresh;         // nothing committed since reset/clear
    int m_occ;
    int m_peak;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit writable(input int b);
        if (m_held && hbuf == b) return 1'b0;
        foreach (cq[i]) if (cq[i] == b) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        cq.delete();
        for (int i = 0; i < NB; i++) mlen[i] = 0;
        wbuf = 0; wcnt = 0; m_held = 0; hbuf = 0;
        m_valid = 0; m_ovf = 0; m_fresh = 1; m_occ = 0; m_peak = 0;
    endtask

    // One clock cycle: drive inputs, compare all outputs, advance the model
    task automatic step(input bit wv, input bit wl, input bit rr, input bit rd, input bit cl);
        bit exp_ready, acc, hs, rel, pre_nonempty;
        int occ_next;
        @(negedge clk_i);
        wr_valid_i = wv; wr_last_i = wl; rd_ready_i = rr; rd_done_i = rd; clear_i = cl;
        #1;
        exp_ready = writable(wbuf);
        chk("wr_ready", {31'd0, wr_ready_o}, {31'd0, exp_ready});
        chk("wr_en", {31'd0, wr_en_o}, {31'd0, wv && exp_ready});
        if (wv && exp_ready) chk("wr_addr", 32'(wr_addr_o), 32'(wbuf * BS + wcnt * WB));
        chk("rd_valid", {31'd0, rd_valid_o}, {31'd0, m_valid});
        if (m_valid) begin
            chk("rd_base", 32'(rd_base_o), 32'(cq[0] * BS));
            chk("rd_len", 32'(rd_len_o), 32'(mlen[cq[0]]));
        end else if (m_held) begin
            chk("rd_base_hold", 32'(rd_base_o), 32'(hbuf * BS));
            chk("rd_len_hold", 32'(rd_len_o), 32'(mlen[hbuf]));
        end else if (m_fresh) begin
            chk("rd_base_rst", 32'(rd_base_o), 32'd0);
            chk("rd_len_rst", 32'(rd_len_o), 32'd0);
        end
        chk("ovf", {31'd0, ovf_o}, {31'd0, m_ovf});
`ifdef NBUF_OCCUPANCY_EN
        chk("occ", 32'(occ_o), 32'(m_occ));
        chk("peak", 32'(peak_o), 32'(m_peak));
`endif
        occ_next = cq.size() + int'(m_held);
        if (cl) begin
            model_reset();
        end else begin
            pre_nonempty = (cq.size() > 0);
            acc = wv && exp_ready;
            hs  = rr && m_valid;
            rel = rd && m_held;
            if (acc) begin
                if (wl || wcnt == WORDS - 1) begin
                    mlen[wbuf] = wcnt + 1;
                    cq.push_back(wbuf);
                    if (!wl) m_ovf = 1;
                    wbuf = (wbuf + 1) % NB;
                    wcnt = 0;
                    m_fresh = 0;
                end else begin
                    wcnt++;
                end
            end
            if (hs) begin
                hbuf = cq.pop_front();
                m_held = 1;
            end
            if (rel) m_held = 0;
            m_valid = !m_held && pre_nonempty && !hs;
            m_occ = occ_next;
            if (m_occ > m_peak) m_peak = m_occ;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        wr_valid_i = 0; wr_last_i = 0; rd_ready_i = 0; rd_done_i = 0; clear_i = 0;
        rst_ni = 1'b0;
        #1;
        chk("rst_wr_ready", {31'd0, wr_ready_o}, 32'd1);
        chk("rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
        chk("rst_rd_base", 32'(rd_base_o), 32'd0);
        chk("rst_rd_len", 32'(rd_len_o), 32'd0);
        model_reset();
        #1 rst_ni = 1'b1;
    endtask

    task automatic words(input int n, input bit last_on_final);
        for (int i = 0; i < n; i++) step(1'b1, last_on_final && (i == n - 1), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_ni = 1'b0;
        wr_valid_i = 0; wr_last_i = 0; rd_ready_i = 0; rd_done_i = 0; clear_i = 0;
        model_reset();
        do_reset();
        idle(1);

        // Fill: four words, last on the fourth, then the buffer is offered
        words(4, 1'b1);
        idle(2);
        $display("scenario fill: done at t=%0t", $time);

        // Backpressure: second buffer committed, producer stalls until release
        words(3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        words(1, 1'b0);
        $display("scenario backpressure: done at t=%0t", $time);

        // Overflow: 16 words with no last, the 17th lands in the next buffer
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        words(17, 1'b0);
        idle(2);
        $display("scenario overflow: done at t=%0t", $time);

        // Commit of buf1 in the same cycle as the release of buf0
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        words(1, 1'b1);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        words(1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        $display("scenario simultaneous: done at t=%0t", $time);

        // Clear mid-fill while buf1 is draining
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        words(1, 1'b1);
        words(1, 1'b1);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        words(5, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        words(2, 1'b0);
        $display("scenario clear: done at t=%0t", $time);

        // Randomized traffic with occasional clears and asynchronous resets
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 9) == 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 299) == 0);
            end
        end
        $display("random traffic: done at t=%0t", $time);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
